// File: rtl/video_timing_gen.sv
// ============================================================================
//  Module      : video_timing_gen
//  Description : Parametrised video timing generator for the Pocket video
//                output. It produces vs/hs/de/line_start, gates rgb with de,
//                and issues early source-pixel/line addresses (x_index,
//                y_index) for the core's fetch logic, with 1x/2x pixel and
//                line replication selected at frame boundaries.
//  Ports       : clk            - dot clock
//                reset_n        - asynchronous active-low reset
//                scale_x/y      - replication select (0 = 1x, 1 = 2x)
//                rgb_in         - pixel from the core
//                vs, hs         - single-cycle sync pulses
//                de, rgb, skip  - video data outputs (skip tied low)
//                line_start     - pulse at column 0 of every row
//                x_index(_valid), y_index(_valid) - fetch addresses
//                frame_count    - frames started since reset
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen #(
  parameter int VISIBLE_WIDTH     = 400,
  parameter int VISIBLE_HEIGHT    = 360,
  parameter int TOTAL_WIDTH       = 500,
  parameter int TOTAL_HEIGHT      = 400,
  parameter int H_START           = TOTAL_WIDTH - VISIBLE_WIDTH,
  parameter int V_START           = TOTAL_HEIGHT - VISIBLE_HEIGHT,
  parameter int HS_COL            = 4,
  parameter int X_PRE             = 0,
  parameter int Y_PRE             = 0,
  parameter int FRAME_FREQUENCY   = 50,
  parameter int DOT_CLOCK         = 0,
  parameter int FRAME_COUNT_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                scale_x,
  input  logic                                scale_y,
  input  logic [23:0]                         rgb_in,
  output logic                                vs,
  output logic                                hs,
  output logic                                de,
  output logic                                skip,
  output logic [23:0]                         rgb,
  output logic                                line_start,
  output logic [$clog2(VISIBLE_WIDTH)-1:0]    x_index,
  output logic                                x_index_valid,
  output logic [$clog2(VISIBLE_HEIGHT)-1:0]   y_index,
  output logic                                y_index_valid,
  output logic [FRAME_COUNT_WIDTH-1:0]        frame_count
);

  localparam int CW = (TOTAL_WIDTH  > 1) ? $clog2(TOTAL_WIDTH)  : 1;
  localparam int RW = (TOTAL_HEIGHT > 1) ? $clog2(TOTAL_HEIGHT) : 1;
  localparam int XW = $clog2(VISIBLE_WIDTH);
  localparam int YW = $clog2(VISIBLE_HEIGHT);

  localparam logic [CW-1:0] c_col_last = CW'(TOTAL_WIDTH - 1);
  localparam logic [CW-1:0] c_h_first  = CW'(H_START);
  localparam logic [CW-1:0] c_h_last   = CW'(H_START + VISIBLE_WIDTH - 1);
  localparam logic [CW-1:0] c_x_first  = CW'(H_START - X_PRE);
  localparam logic [CW-1:0] c_x_last   = CW'(H_START - X_PRE + VISIBLE_WIDTH - 1);
  localparam logic [CW-1:0] c_hs_col   = CW'(HS_COL);
  localparam logic [RW-1:0] c_row_last = RW'(TOTAL_HEIGHT - 1);
  localparam logic [RW-1:0] c_v_first  = RW'(V_START);
  localparam logic [RW-1:0] c_v_last   = RW'(V_START + VISIBLE_HEIGHT - 1);
  localparam logic [RW-1:0] c_y_first  = RW'(V_START - Y_PRE);
  localparam logic [RW-1:0] c_y_last   = RW'(V_START - Y_PRE + VISIBLE_HEIGHT - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (H_START + VISIBLE_WIDTH > TOTAL_WIDTH) begin : g_chk_h_window
    $error("video_timing_gen: H_START+VISIBLE_WIDTH exceeds TOTAL_WIDTH");
  end
  if (V_START + VISIBLE_HEIGHT > TOTAL_HEIGHT) begin : g_chk_v_window
    $error("video_timing_gen: V_START+VISIBLE_HEIGHT exceeds TOTAL_HEIGHT");
  end
  if (X_PRE > H_START) begin : g_chk_x_pre
    $error("video_timing_gen: X_PRE exceeds H_START");
  end
  if (Y_PRE > V_START) begin : g_chk_y_pre
    $error("video_timing_gen: Y_PRE exceeds V_START");
  end
  if (HS_COL >= H_START - X_PRE) begin : g_chk_hs_col
    $error("video_timing_gen: HS_COL must precede the x_index window");
  end
  if ((VISIBLE_WIDTH % 2) != 0 || (VISIBLE_HEIGHT % 2) != 0) begin : g_chk_even
    $error("video_timing_gen: visible dimensions must be even");
  end
  // A DOT_CLOCK of 0 leaves the dot rate unspecified; the rate check only
  // applies once a real rate is supplied.
  if (DOT_CLOCK != 0 &&
      DOT_CLOCK != TOTAL_WIDTH * TOTAL_HEIGHT * FRAME_FREQUENCY) begin : g_chk_rate
    $error("video_timing_gen: DOT_CLOCK inconsistent with frame geometry");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_q, row_d;
  logic                         sx_q, sx_d;
  logic                         sy_q, sy_d;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                         vs_q, vs_d;
  logic                         hs_q, hs_d;
  logic                         de_q, de_d;
  logic                         line_start_q, line_start_d;
  logic [XW-1:0]                x_index_q, x_index_d;
  logic                         x_valid_q, x_valid_d;
  logic [YW-1:0]                y_index_q, y_index_d;
  logic                         y_valid_q, y_valid_d;
  logic                         w_frame_start;

  // Every registered output describes the position the counters move to on
  // this edge, so all decodes below work on the next position (col_d, row_d).
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == c_col_last) begin
      col_d = '0;
      if (row_q == c_row_last) begin
        row_d = '0;
      end else begin
        row_d = row_q + 1'b1;
      end
    end

    w_frame_start = (col_d == '0) && (row_d == '0);

    // Replication modes are sampled only when a new frame begins, so a frame
    // is never rendered with mixed scaling.
    sx_d          = w_frame_start ? scale_x : sx_q;
    sy_d          = w_frame_start ? scale_y : sy_q;
    frame_count_d = w_frame_start ? frame_count_q + 1'b1 : frame_count_q;

    vs_d         = w_frame_start;
    hs_d         = (col_d == c_hs_col);
    line_start_d = (col_d == '0);
    de_d         = (row_d >= c_v_first) && (row_d <= c_v_last) &&
                   (col_d >= c_h_first) && (col_d <= c_h_last);

    // Index windows lead the active window by X_PRE columns / Y_PRE rows.
    y_valid_d = (row_d >= c_y_first) && (row_d <= c_y_last);
    y_index_d = y_valid_d ? YW'((row_d - c_y_first) >> sy_d) : '0;
    x_valid_d = y_valid_d && (col_d >= c_x_first) && (col_d <= c_x_last);
    x_index_d = x_valid_d ? XW'((col_d - c_x_first) >> sx_d) : '0;
  end

  // Reset parks the counters on the last dot of the frame so that the first
  // edge after release lands on (0,0) and starts frame 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q         <= c_col_last;
      row_q         <= c_row_last;
      sx_q          <= 1'b0;
      sy_q          <= 1'b0;
      frame_count_q <= '0;
      vs_q          <= 1'b0;
      hs_q          <= 1'b0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      x_index_q     <= '0;
      x_valid_q     <= 1'b0;
      y_index_q     <= '0;
      y_valid_q     <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      frame_count_q <= frame_count_d;
      vs_q          <= vs_d;
      hs_q          <= hs_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      x_index_q     <= x_index_d;
      x_valid_q     <= x_valid_d;
      y_index_q     <= y_index_d;
      y_valid_q     <= y_valid_d;
    end
  end

  assign vs            = vs_q;
  assign hs            = hs_q;
  assign de            = de_q;
  assign skip          = 1'b0;
  assign rgb           = de_q ? rgb_in : 24'd0;
  assign line_start    = line_start_q;
  assign x_index       = x_index_q;
  assign x_index_valid = x_valid_q;
  assign y_index       = y_index_q;
  assign y_index_valid = y_valid_q;
  assign frame_count   = frame_count_q;

endmodule

`default_nettype wire
